// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : shared AES-128 constants, key-schedule FSM encoding, xtime helper.
// Rev 1.0
// ============================================================================
package aes_pkg;

  localparam int          AES128_ROUNDS    = 10;
  localparam int          AES128_NUM_RKEYS = 11;
  localparam logic [7:0]  RCON_INIT        = 8'h01;
  // Value held before the first expansion; xtime of it yields RCON_INIT.
  localparam logic [7:0]  RCON_RESET       = 8'h8d;

  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } key_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_key_round.sv
`default_nettype none
// ============================================================================
// aes_key_round : one combinational AES-128 key-schedule step.
// Rev 1.0
// ============================================================================
module aes_key_round
  import aes_pkg::*;
(
  input  rkey_t       prev_key_i,
  input  logic [31:0] new_sboxw_i,
  input  logic [7:0]  rcon_i,
  output rkey_t       next_key_o,
  output logic [31:0] sboxw_o
);

  logic [31:0] w_t;
  logic [31:0] w_w4;
  logic [31:0] w_w5;
  logic [31:0] w_w6;
  logic [31:0] w_w7;

  assign sboxw_o = {prev_key_i[23:0], prev_key_i[31:24]};
  assign w_t     = new_sboxw_i ^ {rcon_i, 24'h000000};

  assign w_w4 = prev_key_i[127:96] ^ w_t;
  assign w_w5 = prev_key_i[95:64]  ^ w_w4;
  assign w_w6 = prev_key_i[63:32]  ^ w_w5;
  assign w_w7 = prev_key_i[31:0]   ^ w_w6;

  assign next_key_o = {w_w4, w_w5, w_w6, w_w7};

endmodule : aes_key_round
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// aes_key_expand : AES-128 key expansion, one round key per clock into an
// 11-entry register file. Optional macro AES_KEY_ZEROIZE_EN adds zeroize.
// Rev 1.0
// ============================================================================
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         init,
  input  logic [127:0] key,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw
);

  key_state_e  state_q, state_d;
  rkey_t       prev_key_q, prev_key_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  round_ctr_q, round_ctr_d;
  logic        ready_q, ready_d;
  rkey_t       mem_q [AES128_NUM_RKEYS];

  rkey_t       w_next_key;
  logic        w_wr_en;
  logic [3:0]  w_wr_idx;
  rkey_t       w_wr_data;
  logic        w_clr;
  logic        w_zeroize;

`ifdef AES_KEY_ZEROIZE_EN
  assign w_zeroize = zeroize;
`else
  assign w_zeroize = 1'b0;
`endif

  aes_key_round u_round (
    .prev_key_i  (prev_key_q),
    .new_sboxw_i (new_sboxw),
    .rcon_i      (rcon_q),
    .next_key_o  (w_next_key),
    .sboxw_o     (sboxw)
  );

  always_comb begin
    state_d     = state_q;
    prev_key_d  = prev_key_q;
    rcon_d      = rcon_q;
    round_ctr_d = round_ctr_q;
    ready_d     = ready_q;
    w_wr_en     = 1'b0;
    w_wr_idx    = 4'd0;
    w_wr_data   = w_next_key;
    w_clr       = 1'b0;
    if (w_zeroize) begin
      state_d     = ST_IDLE;
      prev_key_d  = '0;
      round_ctr_d = 4'd0;
      ready_d     = 1'b0;
      w_clr       = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (init) begin
            prev_key_d  = key;
            rcon_d      = RCON_INIT;
            round_ctr_d = 4'd1;
            ready_d     = 1'b0;
            w_wr_en     = 1'b1;
            w_wr_idx    = 4'd0;
            w_wr_data   = key;
            state_d     = ST_GEN;
          end
        end
        ST_GEN: begin
          w_wr_en     = 1'b1;
          w_wr_idx    = round_ctr_q;
          prev_key_d  = w_next_key;
          rcon_d      = xtime(rcon_q);
          round_ctr_d = round_ctr_q + 4'd1;
          if (round_ctr_q == 4'(AES128_ROUNDS)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      prev_key_q  <= '0;
      rcon_q      <= RCON_RESET;
      round_ctr_q <= 4'd0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_key_q  <= prev_key_d;
      rcon_q      <= rcon_d;
      round_ctr_q <= round_ctr_d;
      ready_q     <= ready_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < AES128_NUM_RKEYS; i++) mem_q[i] <= '0;
    end else if (w_clr) begin
      for (int i = 0; i < AES128_NUM_RKEYS; i++) mem_q[i] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < AES128_NUM_RKEYS; i++) begin
        if (w_wr_idx == 4'(i)) mem_q[i] <= w_wr_data;
      end
    end
  end

  // Indices 11..15 match no entry and read as zero.
  always_comb begin
    round_key = '0;
    for (int i = 0; i < AES128_NUM_RKEYS; i++) begin
      if (round == 4'(i)) round_key = mem_q[i];
    end
  end

  assign ready = ready_q;

endmodule : aes_key_expand
`default_nettype wire
